// File: rtl/dcache_nway_ctrl_if.sv
// CPU-side and memory-side signal bundle for the N-way data-cache controller.
interface dcache_nway_ctrl_if #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LINE_BITS = 256
);
    // Memory side
    logic [LINE_BITS-1:0] mem_data_i;
    logic                 mem_ack_i;
    logic [LINE_BITS-1:0] mem_data_o;
    logic [ADDR_W-1:0]    mem_addr_o;
    logic                 mem_enable_o;
    logic                 mem_write_o;

    // CPU side
    logic [31:0]          cpu_data_i;
    logic [ADDR_W-1:0]    cpu_addr_i;
    logic                 cpu_MemRead_i;
    logic                 cpu_MemWrite_i;
    logic [31:0]          cpu_data_o;
    logic                 cpu_stall_o;

    // Statistics
    logic [31:0]          hit_count_o;
    logic [31:0]          miss_count_o;

    // Cache controller view
    modport slave (
        input  mem_data_i, mem_ack_i,
        input  cpu_data_i, cpu_addr_i, cpu_MemRead_i, cpu_MemWrite_i,
        output mem_data_o, mem_addr_o, mem_enable_o, mem_write_o,
        output cpu_data_o, cpu_stall_o, hit_count_o, miss_count_o
    );

    // Pipeline / memory environment view
    modport master (
        output mem_data_i, mem_ack_i,
        output cpu_data_i, cpu_addr_i, cpu_MemRead_i, cpu_MemWrite_i,
        input  mem_data_o, mem_addr_o, mem_enable_o, mem_write_o,
        input  cpu_data_o, cpu_stall_o, hit_count_o, miss_count_o
    );
endinterface

// File: rtl/dcache_nway_ctrl.sv
// N-way set-associative, write-back, write-allocate data cache controller
// with age-based LRU replacement and saturating hit/miss counters.
module dcache_nway_ctrl #(
    parameter int unsigned WAYS      = 2,
    parameter int unsigned SETS      = 16,
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dcache_nway_ctrl_if.slave bus
);
    localparam int unsigned OFF    = $clog2(LINE_BITS / 8);
    localparam int unsigned IDX    = $clog2(SETS);
    localparam int unsigned TAG_W  = ADDR_W - IDX - OFF;
    localparam int unsigned WORDS  = LINE_BITS / 32;
    localparam int unsigned WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned BASE_W = WSEL_W + 5;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned AGE_W  = WAY_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [WAY_W-1:0]     victim_q, victim_d;
    logic                 replay_q, replay_d;
    logic [31:0]          hit_cnt_q, hit_cnt_d;
    logic [31:0]          miss_cnt_q, miss_cnt_d;

    logic                 valid_q [WAYS][SETS];
    logic                 valid_d [WAYS][SETS];
    logic                 dirty_q [WAYS][SETS];
    logic                 dirty_d [WAYS][SETS];
    logic [AGE_W-1:0]     age_q   [WAYS][SETS];
    logic [AGE_W-1:0]     age_d   [WAYS][SETS];
    logic [TAG_W-1:0]     tag_q   [WAYS][SETS];
    logic [TAG_W-1:0]     tag_d   [WAYS][SETS];
    logic [LINE_BITS-1:0] data_q  [WAYS][SETS];
    logic [LINE_BITS-1:0] data_d  [WAYS][SETS];

    logic                 req_c;
    logic                 store_c;
    logic [IDX-1:0]       req_idx_c;
    logic [TAG_W-1:0]     req_tag_c;
    logic [WSEL_W-1:0]    wsel_c;
    logic [BASE_W-1:0]    word_base_c;
    logic                 hit_c;
    logic [WAY_W-1:0]     hit_way_c;
    logic [WAY_W-1:0]     victim_c;

    logic                 stall_c;
    logic [31:0]          rdata_c;
    logic                 mem_en_c;
    logic                 mem_wr_c;
    logic [ADDR_W-1:0]    mem_addr_c;
    logic [LINE_BITS-1:0] mem_line_c;

    logic                 unused_ok;

    assign req_c       = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
    assign store_c     = bus.cpu_MemWrite_i;
    assign req_idx_c   = bus.cpu_addr_i[OFF+IDX-1:OFF];
    assign req_tag_c   = bus.cpu_addr_i[ADDR_W-1:OFF+IDX];
    assign word_base_c = {wsel_c, 5'd0};
    assign unused_ok   = ^bus.cpu_addr_i[1:0];

    // Word-select field only exists when a line holds more than one word
    generate
        if (WORDS > 1) begin : g_wsel
            assign wsel_c = bus.cpu_addr_i[OFF-1:2];
        end else begin : g_wsel_none
            assign wsel_c = '0;
        end
    endgenerate

    // Tag lookup and victim choice; lowest index wins on ties
    always_comb begin
        logic             found_inv;
        logic [AGE_W-1:0] max_age;
        hit_c     = 1'b0;
        hit_way_c = '0;
        victim_c  = '0;
        found_inv = 1'b0;
        max_age   = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (valid_q[w][req_idx_c] && (tag_q[w][req_idx_c] == req_tag_c)) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
        end
        for (int w = 0; w < int'(WAYS); w++) begin
            if (!found_inv && !valid_q[w][req_idx_c]) begin
                found_inv = 1'b1;
                victim_c  = WAY_W'(w);
            end
        end
        if (!found_inv) begin
            for (int w = 0; w < int'(WAYS); w++) begin
                if ((w == 0) || (age_q[w][req_idx_c] > max_age)) begin
                    max_age  = age_q[w][req_idx_c];
                    victim_c = WAY_W'(w);
                end
            end
        end
    end

    // Next-state, array updates and controller outputs
    always_comb begin
        state_d    = state_q;
        victim_d   = victim_q;
        replay_d   = replay_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        age_d      = age_q;
        tag_d      = tag_q;
        data_d     = data_q;
        stall_c    = 1'b0;
        rdata_c    = '0;
        mem_en_c   = 1'b0;
        mem_wr_c   = 1'b0;
        mem_addr_c = '0;
        mem_line_c = '0;

        unique case (state_q)
            IDLE: begin
                replay_d = 1'b0;
                if (req_c && hit_c) begin
                    if (store_c) begin
                        data_d[hit_way_c][req_idx_c][word_base_c +: 32] = bus.cpu_data_i;
                        dirty_d[hit_way_c][req_idx_c] = 1'b1;
                    end else begin
                        rdata_c = data_q[hit_way_c][req_idx_c][word_base_c +: 32];
                    end
                    for (int w = 0; w < int'(WAYS); w++) begin
                        if (WAY_W'(w) == hit_way_c) begin
                            age_d[w][req_idx_c] = '0;
                        end else if (valid_q[w][req_idx_c] &&
                                     (age_q[w][req_idx_c] < age_q[hit_way_c][req_idx_c])) begin
                            age_d[w][req_idx_c] = age_q[w][req_idx_c] + AGE_W'(1);
                        end
                    end
                    if (!replay_q && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                        hit_cnt_d = hit_cnt_q + 32'd1;
                    end
                end else if (req_c) begin
                    stall_c  = 1'b1;
                    victim_d = victim_c;
                    if (miss_cnt_q != 32'hFFFF_FFFF) begin
                        miss_cnt_d = miss_cnt_q + 32'd1;
                    end
                    if (valid_q[victim_c][req_idx_c] && dirty_q[victim_c][req_idx_c]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                stall_c    = 1'b1;
                mem_en_c   = 1'b1;
                mem_wr_c   = 1'b1;
                mem_addr_c = {tag_q[victim_q][req_idx_c], req_idx_c, {OFF{1'b0}}};
                mem_line_c = data_q[victim_q][req_idx_c];
                if (bus.mem_ack_i) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                stall_c    = 1'b1;
                mem_en_c   = 1'b1;
                mem_addr_c = {req_tag_c, req_idx_c, {OFF{1'b0}}};
                if (bus.mem_ack_i) begin
                    data_d[victim_q][req_idx_c]  = bus.mem_data_i;
                    tag_d[victim_q][req_idx_c]   = req_tag_c;
                    valid_d[victim_q][req_idx_c] = 1'b1;
                    dirty_d[victim_q][req_idx_c] = 1'b0;
                    // New line starts oldest so the replay access ages every other way
                    age_d[victim_q][req_idx_c]   = AGE_W'(WAYS - 1);
                    replay_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state, counters and per-line status bits
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            victim_q   <= '0;
            replay_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int w = 0; w < int'(WAYS); w++) begin
                for (int s = 0; s < int'(SETS); s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                    age_q[w][s]   <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            victim_q   <= victim_d;
            replay_q   <= replay_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            age_q      <= age_d;
        end
    end

    // Tag and line storage; meaningless until the valid bit is set
    always_ff @(posedge clk_i) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign bus.cpu_stall_o  = stall_c;
    assign bus.cpu_data_o   = rdata_c;
    assign bus.mem_enable_o = mem_en_c;
    assign bus.mem_write_o  = mem_wr_c;
    assign bus.mem_addr_o   = mem_addr_c;
    assign bus.mem_data_o   = mem_line_c;
    assign bus.hit_count_o  = hit_cnt_q;
    assign bus.miss_count_o = miss_cnt_q;

endmodule

// File: tb/tb_dcache_nway_ctrl.sv
// Directed self-checking bench for dcache_nway_ctrl (2-way, 16 sets, 256-bit lines).
module tb_dcache_nway_ctrl;
    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    dcache_nway_ctrl_if #(.ADDR_W(32), .LINE_BITS(256)) bus ();

    dcache_nway_ctrl #(
        .WAYS(2), .SETS(16), .LINE_BITS(256), .ADDR_W(32)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory model: ack pulses after ten enabled cycles; default line word k = k
    logic [255:0] mem_store [logic [31:0]];
    int           mem_cnt  = 0;
    int           wb_count = 0;
    int           rf_count = 0;
    logic [31:0]  wb_addr  = '0;
    logic [31:0]  rf_addr  = '0;
    logic [255:0] wb_line  = '0;

    function automatic logic [255:0] pattern_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'(k);
        return l;
    endfunction

    always @(posedge clk) begin
        bus.mem_ack_i <= 1'b0;
        if (rst) begin
            mem_cnt = 0;
        end else if (bus.mem_enable_o && (bus.mem_ack_i !== 1'b1)) begin
            if (mem_cnt == 9) begin
                mem_cnt = 0;
                bus.mem_ack_i <= 1'b1;
                if (bus.mem_write_o) begin
                    mem_store[bus.mem_addr_o] = bus.mem_data_o;
                    wb_count++;
                    wb_addr = bus.mem_addr_o;
                    wb_line = bus.mem_data_o;
                end else begin
                    rf_count++;
                    rf_addr = bus.mem_addr_o;
                    if (mem_store.exists(bus.mem_addr_o))
                        bus.mem_data_i <= mem_store[bus.mem_addr_o];
                    else
                        bus.mem_data_i <= pattern_line();
                end
            end else begin
                mem_cnt++;
            end
        end else begin
            mem_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One CPU access held until the stall drops; returns stall cycles and load data
    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output int stalls, output logic [31:0] rd);
        @(negedge clk);
        bus.cpu_addr_i     = a;
        bus.cpu_data_i     = d;
        bus.cpu_MemRead_i  = ~wr;
        bus.cpu_MemWrite_i = wr;
        stalls = 0;
        #1;
        while (bus.cpu_stall_o !== 1'b0) begin
            stalls++;
            if (stalls > 500) begin
                chk("stall_timeout", 32'(stalls), 32'd0);
                break;
            end
            @(negedge clk);
            #1;
        end
        rd = bus.cpu_data_o;
        @(posedge clk);
        #1;
        bus.cpu_MemRead_i  = 1'b0;
        bus.cpu_MemWrite_i = 1'b0;
    endtask

    initial begin
        int          st;
        logic [31:0] rd;
        logic [31:0] w1;

        rst                = 1'b1;
        bus.cpu_addr_i     = '0;
        bus.cpu_data_i     = '0;
        bus.cpu_MemRead_i  = 1'b0;
        bus.cpu_MemWrite_i = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_stall",  32'(bus.cpu_stall_o), 32'd0);
        chk("rst_enable", 32'(bus.mem_enable_o), 32'd0);
        chk("rst_write",  32'(bus.mem_write_o), 32'd0);
        chk("rst_addr",   bus.mem_addr_o, 32'd0);
        chk("rst_mdata",  32'(|bus.mem_data_o), 32'd0);
        chk("rst_cdata",  bus.cpu_data_o, 32'd0);
        chk("rst_hits",   bus.hit_count_o, 32'd0);
        chk("rst_misses", bus.miss_count_o, 32'd0);
        rst = 1'b0;

        // Cold load miss: 1 + 11 + ... = 12 stall cycles, word 0 = 0
        access(1'b0, 32'h0000, '0, st, rd);
        chk("cold_stalls", 32'(st), 32'd12);
        chk("cold_data",   rd, 32'd0);
        chk("cold_misses", bus.miss_count_o, 32'd1);
        chk("cold_hits",   bus.hit_count_o, 32'd0);
        chk("cold_refill", 32'(rf_count), 32'd1);

        // Store hit then load hit
        access(1'b1, 32'h0004, 32'hDEAD_BEEF, st, rd);
        chk("st_stalls", 32'(st), 32'd0);
        access(1'b0, 32'h0004, '0, st, rd);
        chk("ld_stalls", 32'(st), 32'd0);
        chk("ld_data",   rd, 32'hDEAD_BEEF);
        chk("ld_hits",   bus.hit_count_o, 32'd2);

        // Conflict in set 0: 0x0000 (dirty) is LRU when 0x0400 arrives
        access(1'b0, 32'h0200, '0, st, rd);
        chk("c200_stalls", 32'(st), 32'd12);
        chk("c200_wb",     32'(wb_count), 32'd0);
        access(1'b0, 32'h0400, '0, st, rd);
        chk("c400_stalls", 32'(st), 32'd23);
        chk("c400_wb",     32'(wb_count), 32'd1);
        chk("c400_wbaddr", wb_addr, 32'h0000);
        w1 = wb_line[63:32];
        chk("c400_wbword", w1, 32'hDEAD_BEEF);
        chk("c400_rfaddr", rf_addr, 32'h0400);
        chk("c400_misses", bus.miss_count_o, 32'd3);
        access(1'b0, 32'h0204, '0, st, rd);
        chk("c204_stalls", 32'(st), 32'd0);
        chk("c204_data",   rd, 32'd1);
        chk("c204_hits",   bus.hit_count_o, 32'd3);

        // Set 1: touching 0x0020 between fills makes clean 0x0220 the victim
        access(1'b0, 32'h0020, '0, st, rd);
        access(1'b0, 32'h0220, '0, st, rd);
        access(1'b1, 32'h0024, 32'h1234_5678, st, rd);
        chk("s1_touch_stalls", 32'(st), 32'd0);
        access(1'b0, 32'h0420, '0, st, rd);
        chk("s1_stalls", 32'(st), 32'd12);
        chk("s1_wb",     32'(wb_count), 32'd1);
        chk("s1_rfaddr", rf_addr, 32'h0420);
        chk("s1_misses", bus.miss_count_o, 32'd6);
        access(1'b0, 32'h0024, '0, st, rd);
        chk("s1_keep",   rd, 32'h1234_5678);

        // Reset in the middle of ALLOCATE
        @(negedge clk);
        bus.cpu_addr_i    = 32'h0040;
        bus.cpu_MemRead_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("ab_enable_before", 32'(bus.mem_enable_o), 32'd1);
        rst               = 1'b1;
        bus.cpu_MemRead_i = 1'b0;
        @(posedge clk);
        #1;
        chk("ab_enable", 32'(bus.mem_enable_o), 32'd0);
        chk("ab_stall",  32'(bus.cpu_stall_o), 32'd0);
        chk("ab_hits",   bus.hit_count_o, 32'd0);
        chk("ab_misses", bus.miss_count_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        access(1'b0, 32'h0004, '0, st, rd);
        chk("ab_reload_stalls", 32'(st), 32'd12);
        chk("ab_reload_data",   rd, 32'hDEAD_BEEF);
        chk("ab_reload_misses", bus.miss_count_o, 32'd1);

        // Saturation of the hit counter
        @(negedge clk);
        force dut.hit_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.hit_cnt_q;
        access(1'b0, 32'h0004, '0, st, rd);
        chk("sat_stalls", 32'(st), 32'd0);
        chk("sat_hits",   bus.hit_count_o, 32'hFFFF_FFFF);
        chk("sat_misses", bus.miss_count_o, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
